mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, 32, data and address width.
REQ-002 Parameter LOCK_MAX, 16, maximum consecutive loader grants under lock; range 1..255.
REQ-003 Ports clk (input, 1): single clock; reset (input, 1): asynchronous, active-high.
REQ-004 Core port inputs c_req, c_we (1 each); c_addr, c_wdata (WIDTH each).
REQ-005 Core port outputs c_gnt, c_rvalid (1 each); c_rdata (WIDTH).
REQ-006 Loader port inputs l_req, l_we, l_lock (1 each); l_addr, l_wdata (WIDTH each).
REQ-007 Loader port outputs l_gnt, l_rvalid (1 each); l_rdata (WIDTH).
REQ-008 boot_done (input, 1): one-cycle pulse ending boot phase.
REQ-009 Memory side outputs mem_we (1), mem_addr (WIDTH), mem_wdata (WIDTH); input mem_rdata (WIDTH), valid one cycle after address.
REQ-010 Outputs core_hold (1): freezes core PC/IR enables; boot_words (16): loader writes completed in BOOT.

Function
REQ-011 FSM states BOOT, RUN, LOCK; each cycle at most one of c_gnt, l_gnt is high.
REQ-012 Grants are combinational from registered state and current requests; a transaction occupies exactly its grant cycle.
REQ-013 Granted port drives mem_addr/mem_wdata; mem_we = granted port's we; with no grant, mem_we=0 and address/data = 0.
REQ-014 BOOT: l_gnt=l_req, c_gnt=0, core_hold=1; each granted loader write increments boot_words, saturating at 0xFFFF.
REQ-015 BOOT -> RUN on boot_done; a loader grant in that same cycle still completes and counts.
REQ-016 RUN: core_hold=0; a sole requester is granted; on contention, grant the port not granted last (round-robin pointer updates on every grant).
REQ-017 RUN -> LOCK when l_gnt and l_lock are high in the same cycle; lock counter loads 1.
REQ-018 LOCK: l_gnt=l_req, c_gnt=0; counter increments per loader grant; return to RUN when l_lock=0, or when the counter reaches LOCK_MAX, after which round-robin pointer = loader (core wins next contention).
REQ-019 Read with grant in cycle N: requester's rvalid=1 in cycle N+1, rdata = mem_rdata; the other port's rvalid=0.
REQ-020 rdata outputs hold their last captured value when rvalid=0; writes never raise rvalid.
REQ-021 Requests must be held until granted; deasserting c_req/l_req before grant drops the request without side effects.
REQ-022 boot_done outside BOOT is ignored.

Reset
REQ-023 Asserting reset at any time, mid-transaction included, immediately forces: state BOOT, c_gnt=l_gnt=0, c_rvalid=l_rvalid=0, c_rdata=l_rdata=0, mem_we=0, core_hold=1, boot_words=0, lock counter 0, round-robin pointer = loader.
REQ-024 A read pending at reset produces no rvalid after reset release.

Structure
REQ-025 A shared package holds the state enumeration (BOOT, RUN, LOCK), port index constants (CORE=0, LOADER=1), and LOCK_MAX default.
REQ-026 One sub-module, rr_arbiter2 (two-requester round-robin with pointer register), is instantiated for RUN arbitration; the FSM, counters and read-return tracking reside in mem_arbiter.

Verification
REQ-027 Reset, loader writes addresses 0..4 with data 0xA0..0xA4, c_req held high -> c_gnt stays 0, core_hold=1, boot_words=5.
REQ-028 boot_done pulse, then c_req and l_req high for 4 cycles -> grants alternate core, loader, core, loader; core_hold=0.
REQ-029 RUN, core reads address 0x2 with memory content 0xA2 -> c_rvalid=1 one cycle after c_gnt, c_rdata=0xA2, l_rvalid=0.
REQ-030 LOCK_MAX=4, l_lock and both requests held high -> l_gnt high 4 consecutive cycles, then c_gnt in the next cycle.
REQ-031 Reset asserted in the cycle of a granted core read -> no c_rvalid afterwards, state BOOT, boot_words=0.
REQ-032 boot_done pulse in RUN with loader writing -> boot_words unchanged, state RUN.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the core/loader memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int CORE         = 0;
  localparam int LOADER       = 1;
  localparam int LOCK_MAX_DEF = 16;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer holds the index granted last.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] upd_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;

  // Pointer tracks every grant of the enclosing block, not only its own.
  always_comb begin
    ptr_d = ptr_q;
    if (|upd_i) ptr_d = upd_i[LOADER];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b1;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the core and a boot/bulk loader.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [WIDTH-1:0] c_rdata,
  input  logic             l_req,
  input  logic             l_we,
  input  logic             l_lock,
  input  logic [WIDTH-1:0] l_addr,
  input  logic [WIDTH-1:0] l_wdata,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [WIDTH-1:0] l_rdata,
  input  logic             boot_done,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             core_hold,
  output logic [15:0]      boot_words
);
  state_e           state_q, state_d;
  logic [7:0]       lock_cnt_q, lock_cnt_d;
  logic [15:0]      boot_words_q, boot_words_d;
  logic             c_rv_q, l_rv_q;
  logic [WIDTH-1:0] c_rdata_q, l_rdata_q;
  logic [1:0]       rr_req, rr_gnt, gnt;

  assign rr_req = (state_q == RUN) ? {l_req, c_req} : 2'b00;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req_i (rr_req),
    .upd_i (gnt),
    .gnt_o (rr_gnt)
  );

  // Reset gates grants combinationally so nothing reaches memory while held.
  always_comb begin
    gnt = 2'b00;
    case (state_q)
      BOOT:    gnt[LOADER] = l_req;
      RUN:     gnt = rr_gnt;
      LOCK:    gnt[LOADER] = l_req;
      default: gnt = 2'b00;
    endcase
    if (reset) gnt = 2'b00;
  end

  assign c_gnt = gnt[CORE];
  assign l_gnt = gnt[LOADER];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[CORE]) begin
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (gnt[LOADER]) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    boot_words_d = boot_words_q;
    case (state_q)
      BOOT: begin
        if (gnt[LOADER] && l_we && boot_words_q != 16'hFFFF)
          boot_words_d = boot_words_q + 16'd1;
        if (boot_done) state_d = RUN;
      end
      RUN: begin
        // With LOCK_MAX of 1 the entering grant already exhausts the lock.
        if (gnt[LOADER] && l_lock && LOCK_MAX > 1) begin
          state_d    = LOCK;
          lock_cnt_d = 8'd1;
        end
      end
      LOCK: begin
        if (gnt[LOADER]) lock_cnt_d = lock_cnt_q + 8'd1;
        if (!l_lock || (gnt[LOADER] && (lock_cnt_q + 8'd1) >= 8'(LOCK_MAX))) begin
          state_d    = RUN;
          lock_cnt_d = 8'd0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      lock_cnt_q   <= 8'd0;
      boot_words_q <= 16'd0;
      c_rv_q       <= 1'b0;
      l_rv_q       <= 1'b0;
      c_rdata_q    <= '0;
      l_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      boot_words_q <= boot_words_d;
      c_rv_q       <= gnt[CORE] & ~c_we;
      l_rv_q       <= gnt[LOADER] & ~l_we;
      if (c_rv_q) c_rdata_q <= mem_rdata;
      if (l_rv_q) l_rdata_q <= mem_rdata;
    end
  end

  // Read data passes straight through in the return cycle, then holds.
  assign c_rvalid   = c_rv_q;
  assign l_rvalid   = l_rv_q;
  assign c_rdata    = c_rv_q ? mem_rdata : c_rdata_q;
  assign l_rdata    = l_rv_q ? mem_rdata : l_rdata_q;
  assign core_hold  = (state_q == BOOT);
  assign boot_words = boot_words_q;
endmodule
